// File: rtl/ytydla_cacc_accumulator_if.sv
// Handshake/bus bundle for the CACC channel-loop accumulator.
// master = surrounding logic (CMAC, SDP, config); slave = the accumulator.
interface ytydla_cacc_accumulator_if #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 48,
   parameter int LEN_W  = 16
);
   logic              cfg_start;
   logic [LEN_W-1:0]  cfg_accum_len;
   logic [LEN_W-1:0]  cfg_out_num;
   logic              accu2cacc_valid;
   logic [DATA_W-1:0] accu2cmac_aggregation;
   logic              cacc2sdp_valid;
   logic              cacc2sdp_ready;
   logic [ACC_W-1:0]  cacc2sdp_data;
   logic              cacc_busy;
   logic              cacc_done;
   logic              cacc_ovf_err;
   logic              cacc_sat_flag;

   modport master (
      output cfg_start, cfg_accum_len, cfg_out_num,
      output accu2cacc_valid, accu2cmac_aggregation, cacc2sdp_ready,
      input  cacc2sdp_valid, cacc2sdp_data,
      input  cacc_busy, cacc_done, cacc_ovf_err, cacc_sat_flag
   );

   modport slave (
      input  cfg_start, cfg_accum_len, cfg_out_num,
      input  accu2cacc_valid, accu2cmac_aggregation, cacc2sdp_ready,
      output cacc2sdp_valid, cacc2sdp_data,
      output cacc_busy, cacc_done, cacc_ovf_err, cacc_sat_flag
   );
endinterface

// File: rtl/ytydla_cacc_accumulator.sv
// Channel-loop accumulator with 4-entry FWFT result FIFO toward SDP.
// Optional macro YTYDLA_CACC_SAT_EN: saturate instead of wrap, report via cacc_sat_flag.
module ytydla_cacc_accumulator #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 48,
   parameter int LEN_W  = 16
) (
   input  logic                          ytydla_core_clk,
   input  logic                          ytydla_core_rst_n,
   ytydla_cacc_accumulator_if.slave      bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t                  r_state;
   logic [LEN_W-1:0]        r_len_m1;
   logic [LEN_W-1:0]        r_num_m1;
   logic [LEN_W-1:0]        r_beat_cnt;
   logic [LEN_W-1:0]        r_res_cnt;
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_ovf;
   logic                    r_sat;

   logic signed [ACC_W-1:0] r_mem [4];
   logic [1:0]              r_wptr;
   logic [1:0]              r_rptr;
   logic [2:0]              r_count;

   logic signed [DATA_W-1:0] w_agg;
   logic signed [ACC_W-1:0]  w_ext;
   logic signed [ACC_W-1:0]  w_base;
   logic signed [ACC_W-1:0]  w_sum;
   logic                     w_clamp;
   logic                     w_beat;
   logic                     w_last_beat;
   logic                     w_last_res;
   logic                     w_full;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_drop;

   assign w_agg  = bus.accu2cmac_aggregation;
   assign w_ext  = ACC_W'(w_agg);
   assign w_base = (r_beat_cnt == '0) ? '0 : r_acc;

`ifdef YTYDLA_CACC_SAT_EN
   logic signed [ACC_W:0] w_wide;
   assign w_wide  = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_ext);
   // Overflow shows up as disagreement between the guard bit and the sign bit.
   assign w_clamp = w_wide[ACC_W] ^ w_wide[ACC_W-1];
   always_comb begin
      if (!w_clamp)
         w_sum = w_wide[ACC_W-1:0];
      else if (w_wide[ACC_W])
         w_sum = {1'b1, {(ACC_W-1){1'b0}}};
      else
         w_sum = {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign w_clamp = 1'b0;
   assign w_sum   = w_base + w_ext;
`endif

   assign w_beat      = (r_state == ST_RUN) && bus.accu2cacc_valid;
   assign w_last_beat = w_beat && (r_beat_cnt == r_len_m1);
   assign w_last_res  = (r_res_cnt == r_num_m1);
   assign w_full      = (r_count == 3'd4);
   assign w_pop       = (r_count != 3'd0) && bus.cacc2sdp_ready;
   // The adder tree cannot stall, so a push into a full FIFO with no pop is lost.
   assign w_push      = w_last_beat && (!w_full || w_pop);
   assign w_drop      = w_last_beat && w_full && !w_pop;

   always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
      if (!ytydla_core_rst_n) begin
         r_state    <= ST_IDLE;
         r_len_m1   <= '0;
         r_num_m1   <= '0;
         r_beat_cnt <= '0;
         r_res_cnt  <= '0;
         r_acc      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.cfg_start) begin
                  r_len_m1   <= (bus.cfg_accum_len == '0) ? '0 : bus.cfg_accum_len - LEN_W'(1);
                  r_num_m1   <= (bus.cfg_out_num == '0) ? '0 : bus.cfg_out_num - LEN_W'(1);
                  r_beat_cnt <= '0;
                  r_res_cnt  <= '0;
                  r_acc      <= '0;
                  r_ovf      <= 1'b0;
                  r_sat      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_beat) begin
                  if (w_clamp)
                     r_sat <= 1'b1;
                  if (w_last_beat) begin
                     r_acc      <= '0;
                     r_beat_cnt <= '0;
                     r_res_cnt  <= r_res_cnt + LEN_W'(1);
                     if (w_drop)
                        r_ovf <= 1'b1;
                     if (w_last_res)
                        r_state <= ST_DRAIN;
                  end else begin
                     r_acc      <= w_sum;
                     r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (r_count == 3'd0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
      if (!ytydla_core_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < 4; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_sum;
            r_wptr        <= r_wptr + 2'd1;
         end
         if (w_pop)
            r_rptr <= r_rptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.cacc2sdp_valid = (r_count != 3'd0);
   assign bus.cacc2sdp_data  = r_mem[r_rptr];
   assign bus.cacc_busy      = r_busy;
   assign bus.cacc_done      = r_done;
   assign bus.cacc_ovf_err   = r_ovf;
   assign bus.cacc_sat_flag  = r_sat;
endmodule

// File: tb/tb_ytydla_cacc_accumulator.sv
// Directed self-checking bench for ytydla_cacc_accumulator (48-bit main DUT, 32-bit DUT for saturation).
module tb_ytydla_cacc_accumulator;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ytydla_cacc_accumulator_if #(.DATA_W(32), .ACC_W(48), .LEN_W(16)) bus ();
   ytydla_cacc_accumulator_if #(.DATA_W(32), .ACC_W(32), .LEN_W(16)) sbus ();

   ytydla_cacc_accumulator #(.DATA_W(32), .ACC_W(48), .LEN_W(16)) dut (
      .ytydla_core_clk   (clk),
      .ytydla_core_rst_n (rst_n),
      .bus               (bus.slave)
   );

   ytydla_cacc_accumulator #(.DATA_W(32), .ACC_W(32), .LEN_W(16)) dut_sat (
      .ytydla_core_clk   (clk),
      .ytydla_core_rst_n (rst_n),
      .bus               (sbus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [47:0] got_q [$];

   always @(posedge clk) begin
      if (bus.cacc2sdp_valid && bus.cacc2sdp_ready) begin
         got_q.push_back(bus.cacc2sdp_data);
         $display("result %0d: 0x%012h", got_q.size() - 1, bus.cacc2sdp_data);
      end
   end

   task automatic start_op(input logic [15:0] len, input logic [15:0] num);
      @(negedge clk);
      bus.cfg_accum_len = len;
      bus.cfg_out_num   = num;
      bus.cfg_start     = 1'b1;
      @(negedge clk);
      bus.cfg_start     = 1'b0;
   endtask

   task automatic beat(input logic [31:0] v);
      bus.accu2cacc_valid       = 1'b1;
      bus.accu2cmac_aggregation = v;
      @(negedge clk);
      bus.accu2cacc_valid       = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (bus.cacc_done) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_checks++; if (bus.cacc2sdp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.cacc2sdp_valid); end
      n_checks++; if (bus.cacc2sdp_data !== 48'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", bus.cacc2sdp_data); end
      n_checks++; if (bus.cacc_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.cacc_busy); end
      n_checks++; if (bus.cacc_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus.cacc_done); end
      n_checks++; if (bus.cacc_ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", bus.cacc_ovf_err); end
      n_checks++; if (bus.cacc_sat_flag !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %b want 0", bus.cacc_sat_flag); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int b;
      bit seen;
      bus.cacc2sdp_ready = 1'b1;
      b = got_q.size();
      start_op(16'd4, 16'd2);
      beat(1); beat(2); beat(3); beat(4);
      beat(-5); beat(6); beat(7); beat(8);
      wait_done(seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", seen); end
      n_checks++; if (bus.cacc_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", bus.cacc_busy); end
      n_checks++; if (got_q.size() - b !== 2) begin n_fail++; $display("FAIL basic_count got %0d want 2", got_q.size() - b); end
      n_checks++; if (got_q[b] !== 48'd10) begin n_fail++; $display("FAIL basic_r0 got %0d want 10", got_q[b]); end
      n_checks++; if (got_q[b+1] !== 48'd16) begin n_fail++; $display("FAIL basic_r1 got %0d want 16", got_q[b+1]); end
      @(negedge clk);
      n_checks++; if (bus.cacc_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.cacc_done); end
   endtask

   task automatic test_zero_len;
      int b;
      bit seen;
      bus.cacc2sdp_ready = 1'b1;
      b = got_q.size();
      start_op(16'd0, 16'd0);
      beat(-7);
      wait_done(seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", seen); end
      n_checks++; if (got_q.size() - b !== 1) begin n_fail++; $display("FAIL zero_count got %0d want 1", got_q.size() - b); end
      n_checks++; if (got_q[b] !== 48'hFFFF_FFFF_FFF9) begin n_fail++; $display("FAIL zero_r0 got %h want fffffffffff9", got_q[b]); end
   endtask

   task automatic test_backpressure;
      int b;
      bit seen;
      bus.cacc2sdp_ready = 1'b0;
      b = got_q.size();
      start_op(16'd1, 16'd6);
      for (int i = 1; i <= 6; i++) beat(10 * i);
      n_checks++; if (bus.cacc_ovf_err !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b want 1", bus.cacc_ovf_err); end
      n_checks++; if (bus.cacc2sdp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", bus.cacc2sdp_valid); end
      n_checks++; if (bus.cacc2sdp_data !== 48'd10) begin n_fail++; $display("FAIL bp_head got %0d want 10", bus.cacc2sdp_data); end
      n_checks++; if (bus.cacc_busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b want 1", bus.cacc_busy); end
      bus.cacc2sdp_ready = 1'b1;
      wait_done(seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", seen); end
      n_checks++; if (got_q.size() - b !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got_q.size() - b); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (got_q[b+i] !== 48'(10 * (i + 1))) begin n_fail++; $display("FAIL bp_r%0d got %0d want %0d", i, got_q[b+i], 10 * (i + 1)); end
      end
      // full FIFO with a simultaneous pop must not drop
      bus.cacc2sdp_ready = 1'b0;
      b = got_q.size();
      start_op(16'd1, 16'd5);
      for (int i = 1; i <= 4; i++) beat(10 * i);
      bus.cacc2sdp_ready = 1'b1;
      beat(50);
      wait_done(seen);
      n_checks++; if (bus.cacc_ovf_err !== 1'b0) begin n_fail++; $display("FAIL full_pop_ovf got %b want 0", bus.cacc_ovf_err); end
      n_checks++; if (got_q.size() - b !== 5) begin n_fail++; $display("FAIL full_pop_count got %0d want 5", got_q.size() - b); end
      n_checks++; if (got_q[b+4] !== 48'd50) begin n_fail++; $display("FAIL full_pop_r4 got %0d want 50", got_q[b+4]); end
   endtask

   task automatic test_gaps;
      int b;
      bit seen;
      bus.cacc2sdp_ready = 1'b1;
      b = got_q.size();
      beat(999);
      start_op(16'd3, 16'd1);
      beat(100); @(negedge clk);
      beat(200); @(negedge clk);
      beat(300);
      beat(777);
      wait_done(seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b want 1", seen); end
      n_checks++; if (got_q.size() - b !== 1) begin n_fail++; $display("FAIL gap_count got %0d want 1", got_q.size() - b); end
      n_checks++; if (got_q[b] !== 48'd600) begin n_fail++; $display("FAIL gap_r0 got %0d want 600", got_q[b]); end
   endtask

   task automatic test_back_to_back;
      int b;
      bit seen;
      bus.cacc2sdp_ready = 1'b1;
      b = got_q.size();
      start_op(16'd1, 16'd4);
      beat(5);
      n_checks++; if (bus.cacc2sdp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency_valid got %b want 1", bus.cacc2sdp_valid); end
      n_checks++; if (bus.cacc2sdp_data !== 48'd5) begin n_fail++; $display("FAIL b2b_latency_data got %0d want 5", bus.cacc2sdp_data); end
      beat(6);
      n_checks++; if (bus.cacc2sdp_data !== 48'd6) begin n_fail++; $display("FAIL b2b_second got %0d want 6", bus.cacc2sdp_data); end
      beat(7); beat(8);
      wait_done(seen);
      n_checks++; if (got_q.size() - b !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", got_q.size() - b); end
      n_checks++; if (got_q[b+3] !== 48'd8) begin n_fail++; $display("FAIL b2b_r3 got %0d want 8", got_q[b+3]); end
   endtask

   task automatic test_saturation;
      logic [31:0] exp_data;
      logic        exp_flag;
      bit          seen;
`ifdef YTYDLA_CACC_SAT_EN
      exp_data = 32'h7FFF_FFFF; exp_flag = 1'b1;
`else
      exp_data = 32'h8000_0000; exp_flag = 1'b0;
`endif
      sbus.cacc2sdp_ready = 1'b0;
      @(negedge clk);
      sbus.cfg_accum_len = 16'd2; sbus.cfg_out_num = 16'd1; sbus.cfg_start = 1'b1;
      @(negedge clk);
      sbus.cfg_start = 1'b0;
      sbus.accu2cacc_valid = 1'b1; sbus.accu2cmac_aggregation = 32'h7FFF_FFFF;
      @(negedge clk);
      sbus.accu2cmac_aggregation = 32'h1;
      @(negedge clk);
      sbus.accu2cacc_valid = 1'b0;
      n_checks++; if (sbus.cacc2sdp_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid got %b want 1", sbus.cacc2sdp_valid); end
      n_checks++; if (sbus.cacc2sdp_data !== exp_data) begin n_fail++; $display("FAIL sat_data got %h want %h", sbus.cacc2sdp_data, exp_data); end
      n_checks++; if (sbus.cacc_sat_flag !== exp_flag) begin n_fail++; $display("FAIL sat_flag got %b want %b", sbus.cacc_sat_flag, exp_flag); end
      $display("sat result 0x%08h flag %b", sbus.cacc2sdp_data, sbus.cacc_sat_flag);
      sbus.cacc2sdp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (sbus.cacc_done) seen = 1'b1;
         else @(negedge clk);
      end
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL sat_done got %b want 1", seen); end
   endtask

   task automatic test_reset_mid_run;
      int b;
      bit seen;
      bus.cacc2sdp_ready = 1'b1;
      start_op(16'd4, 16'd2);
      beat(1); beat(2);
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.cacc_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", bus.cacc_busy); end
      n_checks++; if (bus.cacc2sdp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", bus.cacc2sdp_valid); end
      n_checks++; if (bus.cacc2sdp_data !== 48'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", bus.cacc2sdp_data); end
      n_checks++; if (bus.cacc_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b want 0", bus.cacc_done); end
      @(negedge clk);
      rst_n = 1'b1;
      b = got_q.size();
      start_op(16'd4, 16'd1);
      beat(3); beat(3); beat(3); beat(3);
      wait_done(seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_rst_redone got %b want 1", seen); end
      n_checks++; if (got_q.size() - b !== 1) begin n_fail++; $display("FAIL mid_rst_count got %0d want 1", got_q.size() - b); end
      n_checks++; if (got_q[b] !== 48'd12) begin n_fail++; $display("FAIL mid_rst_r0 got %0d want 12", got_q[b]); end
   endtask

   initial begin
      bus.cfg_start = 1'b0; bus.cfg_accum_len = '0; bus.cfg_out_num = '0;
      bus.accu2cacc_valid = 1'b0; bus.accu2cmac_aggregation = '0; bus.cacc2sdp_ready = 1'b0;
      sbus.cfg_start = 1'b0; sbus.cfg_accum_len = '0; sbus.cfg_out_num = '0;
      sbus.accu2cacc_valid = 1'b0; sbus.accu2cmac_aggregation = '0; sbus.cacc2sdp_ready = 1'b0;
      test_reset;
      test_basic;
      test_zero_len;
      test_backpressure;
      test_gaps;
      test_back_to_back;
      test_saturation;
      test_reset_mid_run;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ytydla_cacc_accumulator.md
# ytydla_cacc_accumulator

Channel-loop accumulator directly downstream of the CMAC 64-input adder tree. It sums a configured number of successive per-cycle aggregations into one wide signed partial result and buffers results in a 4-entry FIFO. The FIFO drains to the SDP over a valid/ready handshake. Operation framing, length counting, overflow detection and a completion pulse are handled here, because the adder tree cannot be stalled.

## Interface
Parameters:
- DATA_W, default 32: width of the incoming aggregation; must equal `YTYDLA_DATA_LENGTH`.
- ACC_W, default 48: accumulator and output width. Must be ≥ DATA_W.
- LEN_W, default 16: width of the configuration counts.

Ports:
- ytydla_core_clk  in  1  clock; all state on posedge.
- ytydla_core_rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; starts an operation; sampled only in IDLE.
- cfg_accum_len  in  LEN_W  partial sums per result; 0 is treated as 1; latched on start.
- cfg_out_num  in  LEN_W  results per operation; 0 is treated as 1; latched on start.
- accu2cacc_valid  in  1  qualifies accu2cmac_aggregation this cycle.
- accu2cmac_aggregation  in  DATA_W  signed aggregation from the adder tree.
- cacc2sdp_valid  out  1  FIFO head valid.
- cacc2sdp_ready  in  1  SDP accepts the head.
- cacc2sdp_data  out  ACC_W  signed result at the FIFO head.
- cacc_busy  out  1  high in RUN and DRAIN.
- cacc_done  out  1  one-cycle completion pulse.
- cacc_ovf_err  out  1  sticky; a result was dropped because the FIFO was full.
- cacc_sat_flag  out  1  sticky; saturation occurred (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on cfg_start:
  - latches both lengths;
  - clears the beat counter, result counter, accumulator, cacc_ovf_err and cacc_sat_flag.
- RUN, accumulation:
  - Each valid beat computes sum = (first beat of group ? 0 : acc) + sign_extend(aggregation).
  - On beats 1..N−1, acc <= sum.
  - On beat N, sum is pushed to the FIFO, acc clears and the result counter increments.
- RUN → DRAIN on the edge that pushes result cfg_out_num.
- DRAIN → IDLE when the FIFO is empty. cacc_done pulses for the one cycle after that transition edge.
- Valid beats are ignored in IDLE and DRAIN. cfg_start is ignored in RUN and DRAIN.
- FIFO: 4 entries, first-word fall-through.
  - Pop when cacc2sdp_valid && cacc2sdp_ready.
  - Push to a full FIFO in the same cycle as a pop is accepted.
  - Push to a full FIFO without a pop drops the result and sets cacc_ovf_err. The result counter still increments, so operation framing is preserved.
- Reset mid-operation returns to IDLE immediately. The FIFO is emptied and all counters are cleared.

## Timing
- Reset values:
  - cacc2sdp_valid, cacc_busy, cacc_done, cacc_ovf_err, cacc_sat_flag = 0;
  - cacc2sdp_data = 0;
  - FSM = IDLE.
- Start latency: cfg_start sampled at edge k puts the block in RUN after edge k. A valid beat in the cycle after edge k is accepted as beat 1.
- Result latency: the final beat of a group is sampled at edge k. cacc2sdp_valid is high after edge k if the FIFO was empty.
- Throughput: one beat per cycle, including back-to-back groups with N = 1, which produce one result per cycle.
- cacc2sdp_data holds stable while valid && !ready.
- cacc_busy drops on the same edge that raises cacc_done.

## Configuration
- Macro YTYDLA_CACC_SAT_EN.
  - Defined: the accumulator saturates at the signed ACC_W limits, to 2^(ACC_W−1)−1 or −2^(ACC_W−1). Any clamp sets cacc_sat_flag.
  - Undefined: the accumulator wraps modulo 2^ACC_W and cacc_sat_flag is tied to 0.

## Test plan
- Basic group: len=4, out_num=2, beats 1,2,3,4,−5,6,7,8 with ready held high.
  - Results 10 then 16.
  - One cacc_done pulse after the FIFO empties.
  - cacc_busy then low.
- Zero lengths: len=0, out_num=0, one beat of −7.
  - Exactly one result, −7 (sign-extended to 48 bits).
  - Then done.
- Backpressure: len=1, out_num=6, ready low for 6 beats.
  - First 4 results buffered, results 5 and 6 dropped, cacc_ovf_err=1.
  - After ready rises, 4 results are drained and done pulses.
  - With ready high in the full cycle, no drop occurs.
- Gaps: len=3 with valid toggling every other cycle, beats 100,200,300 → result 600. Beats offered while in IDLE or DRAIN are ignored.
- Saturation:
  - ACC_W=32, DATA_W=32, len=2, beats 0x7FFFFFFF,1.
  - With the macro defined: 0x7FFFFFFF and cacc_sat_flag=1.
  - Without the macro: 0x80000000 and cacc_sat_flag=0.
- Reset mid-RUN after 2 of 4 beats.
  - All outputs return to 0 and the FIFO is empty.
  - A new start then gives correct results with no residue from the aborted operation.
